// File: rtl/apb_regfile_pkg.sv
// Shared types and helpers for the APB register-file completer.
package apb_regfile_pkg;

  // Widest register the strobe merge supports; callers zero-extend and truncate.
  localparam int MERGE_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READY
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_ALIGN,
    ERR_RANGE,
    ERR_RO,
    ERR_PROT
  } err_e;

  function automatic logic [MERGE_W-1:0] strb_merge(
    input logic [MERGE_W-1:0]   old_d,
    input logic [MERGE_W-1:0]   new_d,
    input logic [MERGE_W/8-1:0] strb
  );
    logic [MERGE_W-1:0] res;
    res = old_d;
    for (int k = 0; k < MERGE_W/8; k++) begin
      if (strb[k]) res[k*8 +: 8] = new_d[k*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_regfile_decode.sv
// Combinational address/protection decode: register index plus a single error flag.
module apb_regfile_decode
  import apb_regfile_pkg::*;
#(
  parameter int G_REGWIDTH    = 32,
  parameter int G_ADDR_WIDTH  = 32,
  parameter int G_NUM_REGS    = 16,
  parameter int G_SECURE_ONLY = 0
) (
  input  logic [G_ADDR_WIDTH-1:0]       paddr,
  input  logic                          pwrite,
  input  logic [2:0]                    pprot,
  output logic [$clog2(G_NUM_REGS)-1:0] index,
  output logic                          err
);

  localparam int B     = $clog2(G_REGWIDTH/8);
  localparam int IDX_W = $clog2(G_NUM_REGS);
  localparam logic [G_ADDR_WIDTH-1:0] ALIGN_MASK = G_ADDR_WIDTH'(G_REGWIDTH/8 - 1);

  err_e cause;
  logic unused_prot;

  assign index       = paddr[B +: IDX_W];
  assign unused_prot = pprot[0] ^ pprot[2];

  // First matching cause wins; only "any error" leaves this block.
  always_comb begin
    cause = ERR_NONE;
    if ((paddr & ALIGN_MASK) != '0)
      cause = ERR_ALIGN;
    else if ((paddr >> (B + IDX_W)) != '0)
      cause = ERR_RANGE;
    else if (pwrite && (index == '0))
      cause = ERR_RO;
    else if ((G_SECURE_ONLY != 0) && pprot[1])
      cause = ERR_PROT;
  end

  assign err = (cause != ERR_NONE);

endmodule

// File: rtl/apb_regfile_slave.sv
// APB completer backed by a small register bank with strobes, wait states and slverr.
module apb_regfile_slave
  import apb_regfile_pkg::*;
#(
  parameter int G_REGWIDTH    = 32,
  parameter int G_ADDR_WIDTH  = 32,
  parameter int G_NUM_REGS    = 16,
  parameter int G_WAIT_STATES = 0,
  parameter logic [G_REGWIDTH-1:0] G_ID_VALUE = 32'hA5B0_0001,
  parameter int G_SECURE_ONLY = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_apb_psel,
  input  logic                             s_apb_penable,
  input  logic                             s_apb_pwrite,
  input  logic [2:0]                       s_apb_pprot,
  input  logic [G_ADDR_WIDTH-1:0]          s_apb_paddr,
  input  logic [G_REGWIDTH-1:0]            s_apb_pwdata,
  input  logic [G_REGWIDTH/8-1:0]          s_apb_pstrb,
  output logic                             s_apb_pready,
  output logic [G_REGWIDTH-1:0]            s_apb_prdata,
  output logic                             s_apb_pslverr,
  output logic [G_NUM_REGS*G_REGWIDTH-1:0] regs_o,
  output logic [G_NUM_REGS-1:0]            wr_pulse_o
);

  localparam int IDX_W = $clog2(G_NUM_REGS);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, dec_idx, cur_idx;
  logic                   err_q, dec_err, cur_err;
  logic                   wr_q, cur_wr;
  logic                   setup, commit, to_ready;
  logic [G_REGWIDTH-1:0]  regs_q [G_NUM_REGS];
  logic [G_REGWIDTH-1:0]  rd_val, wr_val;
  logic                   pready_q, pslverr_q;
  logic [G_REGWIDTH-1:0]  prdata_q;
  logic [G_NUM_REGS-1:0]  pulse_q;

  apb_regfile_decode #(
    .G_REGWIDTH   (G_REGWIDTH),
    .G_ADDR_WIDTH (G_ADDR_WIDTH),
    .G_NUM_REGS   (G_NUM_REGS),
    .G_SECURE_ONLY(G_SECURE_ONLY)
  ) u_decode (
    .paddr (s_apb_paddr),
    .pwrite(s_apb_pwrite),
    .pprot (s_apb_pprot),
    .index (dec_idx),
    .err   (dec_err)
  );

  assign setup = s_apb_psel && !s_apb_penable;

  // With zero wait states IDLE goes straight to READY, so use the live decode.
  assign cur_idx = (state_q == IDLE) ? dec_idx      : idx_q;
  assign cur_err = (state_q == IDLE) ? dec_err      : err_q;
  assign cur_wr  = (state_q == IDLE) ? s_apb_pwrite : wr_q;

  assign rd_val   = (cur_idx == '0) ? G_ID_VALUE : regs_q[cur_idx];
  assign wr_val   = G_REGWIDTH'(strb_merge(MERGE_W'(regs_q[idx_q]), MERGE_W'(s_apb_pwdata),
                                           (MERGE_W/8)'(s_apb_pstrb)));
  assign commit   = (state_q == READY) && s_apb_psel && s_apb_penable && wr_q && !err_q;
  assign to_ready = (state_d == READY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          cnt_d   = 4'(G_WAIT_STATES);
          state_d = (G_WAIT_STATES == 0) ? READY : WAIT;
        end
      end
      WAIT: begin
        if (!s_apb_psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= 4'd1) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      READY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transfer attributes captured at setup, held through WAIT/READY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      err_q <= 1'b0;
      wr_q  <= 1'b0;
    end else if ((state_q == IDLE) && setup) begin
      idx_q <= dec_idx;
      err_q <= dec_err;
      wr_q  <= s_apb_pwrite;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < G_NUM_REGS; i++) regs_q[i] <= '0;
    end else if (commit) begin
      regs_q[idx_q] <= wr_val;
    end
  end

  // Response and pulse outputs are registered so nothing from the bus reaches them combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      pulse_q   <= '0;
    end else begin
      pready_q  <= to_ready;
      pslverr_q <= to_ready && cur_err;
      prdata_q  <= (to_ready && !cur_err && !cur_wr) ? rd_val : '0;
      pulse_q   <= '0;
      if (commit) pulse_q[idx_q] <= 1'b1;
    end
  end

  assign s_apb_pready  = pready_q;
  assign s_apb_pslverr = pslverr_q;
  assign s_apb_prdata  = prdata_q;
  assign wr_pulse_o    = pulse_q;

  for (genvar i = 0; i < G_NUM_REGS; i++) begin : g_export
    assign regs_o[i*G_REGWIDTH +: G_REGWIDTH] = (i == 0) ? G_ID_VALUE : regs_q[i];
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: three instances (no wait, 3 waits, secure-only) on one clock.
`timescale 1ns/1ps
module tb_apb_regfile_slave;

  localparam int W = 32;
  localparam int N = 16;
  localparam logic [31:0] ID = 32'hA5B0_0001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  psel;
  logic        penable, pwrite;
  logic [2:0]  pprot;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;

  logic          pready_w  [3];
  logic          pslverr_w [3];
  logic [31:0]   prdata_w  [3];
  logic [N*W-1:0] regs_w   [3];
  logic [N-1:0]  pulse_w   [3];

  apb_regfile_slave #(.G_WAIT_STATES(0), .G_SECURE_ONLY(0)) u_dut0 (
    .clk(clk), .rst(rst), .s_apb_psel(psel[0]), .s_apb_penable(penable),
    .s_apb_pwrite(pwrite), .s_apb_pprot(pprot), .s_apb_paddr(paddr),
    .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb), .s_apb_pready(pready_w[0]),
    .s_apb_prdata(prdata_w[0]), .s_apb_pslverr(pslverr_w[0]),
    .regs_o(regs_w[0]), .wr_pulse_o(pulse_w[0]));

  apb_regfile_slave #(.G_WAIT_STATES(3), .G_SECURE_ONLY(0)) u_dut1 (
    .clk(clk), .rst(rst), .s_apb_psel(psel[1]), .s_apb_penable(penable),
    .s_apb_pwrite(pwrite), .s_apb_pprot(pprot), .s_apb_paddr(paddr),
    .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb), .s_apb_pready(pready_w[1]),
    .s_apb_prdata(prdata_w[1]), .s_apb_pslverr(pslverr_w[1]),
    .regs_o(regs_w[1]), .wr_pulse_o(pulse_w[1]));

  apb_regfile_slave #(.G_WAIT_STATES(0), .G_SECURE_ONLY(1)) u_dut2 (
    .clk(clk), .rst(rst), .s_apb_psel(psel[2]), .s_apb_penable(penable),
    .s_apb_pwrite(pwrite), .s_apb_pprot(pprot), .s_apb_paddr(paddr),
    .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb), .s_apb_pready(pready_w[2]),
    .s_apb_prdata(prdata_w[2]), .s_apb_pslverr(pslverr_w[2]),
    .regs_o(regs_w[2]), .wr_pulse_o(pulse_w[2]));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  // Pulse counters: all pulses per instance, plus register 2 of instance 0.
  int pulse_cnt [3];
  int pulse2_cnt;
  initial begin
    for (int i = 0; i < 3; i++) pulse_cnt[i] = 0;
    pulse2_cnt = 0;
  end
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) pulse_cnt[i] += $countones(pulse_w[i]);
    pulse2_cnt += int'(pulse_w[0][2]);
  end

  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                      input logic [31:0] exp_rd, input logic exp_err);
    exp_t  e, got_e;
    int    lat;
    bit    done;
    string tag;
    tag   = $sformatf("d%0d_%s_%0h", d, wr ? "wr" : "rd", addr);
    e.rd  = exp_rd;
    e.err = exp_err;
    e.lat = (d == 1) ? 4 : 1;
    @(posedge clk); #1;
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    pstrb   = strb;
    pprot   = prot;
    sb.push_back(e);
    @(posedge clk); #1;
    penable = 1'b1;
    lat  = 1;
    done = 0;
    while (!done && lat <= 20) begin
      @(negedge clk);
      if (pready_w[d]) done = 1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    got_e = sb.pop_front();
    if (!done) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({tag, "_lat"},    64'(lat),          64'(got_e.lat));
      chk({tag, "_prdata"}, 64'(prdata_w[d]),  64'(got_e.rd));
      chk({tag, "_slverr"}, 64'(pslverr_w[d]), 64'(got_e.err));
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel    = '0;
    penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=stuck exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    psel = '0; penable = 0; pwrite = 0; pprot = '0;
    paddr = '0; pwdata = '0; pstrb = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_pready%0d", d),  64'(pready_w[d]),  64'd0);
      chk($sformatf("rst_prdata%0d", d),  64'(prdata_w[d]),  64'd0);
      chk($sformatf("rst_pslverr%0d", d), 64'(pslverr_w[d]), 64'd0);
      chk($sformatf("rst_pulse%0d", d),   64'(pulse_w[d]),   64'd0);
    end
    chk("rst_reg2", 64'(regs_w[0][2*W +: W]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Zero-wait instance: ID, reads, strobed writes
    xfer(0, 0, 32'h00, 0, 4'h0, 3'b000, ID, 0);
    xfer(0, 0, 32'h04, 0, 4'h0, 3'b000, 32'h0, 0);
    xfer(0, 1, 32'h08, 32'h1122_3344, 4'b0101, 3'b000, 32'h0, 0);
    xfer(0, 0, 32'h08, 0, 4'h0, 3'b000, 32'h0022_0044, 0);
    chk("pulse2_once", 64'(pulse2_cnt), 64'd1);
    chk("regs_o_2", 64'(regs_w[0][2*W +: W]), 64'h0022_0044);
    xfer(0, 1, 32'h08, 32'hAABB_CCDD, 4'b1010, 3'b000, 32'h0, 0);
    xfer(0, 0, 32'h08, 0, 4'h0, 3'b000, 32'hAA22_CC44, 0);
    xfer(0, 1, 32'h08, 32'hFFFF_FFFF, 4'b0000, 3'b000, 32'h0, 0);
    xfer(0, 0, 32'h08, 0, 4'h0, 3'b000, 32'hAA22_CC44, 0);
    chk("pulse2_strb0", 64'(pulse2_cnt), 64'd3);

    // Error responses
    xfer(0, 0, 32'h40, 0, 4'h0, 3'b000, 32'h0, 1);
    xfer(0, 1, 32'h02, 32'h5555_5555, 4'hF, 3'b000, 32'h0, 1);
    xfer(0, 1, 32'h00, 32'h5555_5555, 4'hF, 3'b000, 32'h0, 1);
    xfer(0, 0, 32'h00, 0, 4'h0, 3'b000, ID, 0);
    idle();
    @(negedge clk);
    chk("err_no_pulse", 64'(pulse_cnt[0]), 64'd3);

    // Three wait states, including back-to-back reads
    xfer(1, 1, 32'h3C, 32'hDEAD_BEEF, 4'hF, 3'b000, 32'h0, 0);
    xfer(1, 0, 32'h3C, 0, 4'h0, 3'b000, 32'hDEAD_BEEF, 0);
    xfer(1, 0, 32'h04, 0, 4'h0, 3'b000, 32'h0, 0);
    idle();

    // Secure-only instance
    xfer(2, 1, 32'h04, 32'h1234_5678, 4'hF, 3'b010, 32'h0, 1);
    xfer(2, 0, 32'h04, 0, 4'h0, 3'b000, 32'h0, 0);
    xfer(2, 1, 32'h04, 32'h1234_5678, 4'hF, 3'b000, 32'h0, 0);
    xfer(2, 0, 32'h04, 0, 4'h0, 3'b000, 32'h1234_5678, 0);
    idle();
    @(negedge clk);
    chk("secure_pulses", 64'(pulse_cnt[2]), 64'd1);

    // Abort in WAIT
    @(posedge clk); #1;
    psel = 3'b010; penable = 0; pwrite = 1; paddr = 32'h10;
    pwdata = 32'h0000_0055; pstrb = 4'hF; pprot = 3'b000;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    psel = '0; penable = 0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= pready_w[1];
    end
    chk("abort_no_ready", 64'(seen), 64'd0);
    xfer(1, 0, 32'h10, 0, 4'h0, 3'b000, 32'h0, 0);
    idle();
    @(negedge clk);
    chk("abort_no_pulse", 64'(pulse_cnt[1]), 64'd1);

    // Reset asserted in the middle of a waited write
    @(posedge clk); #1;
    psel = 3'b010; penable = 0; pwrite = 1; paddr = 32'h20;
    pwdata = 32'hCAFE_F00D; pstrb = 4'hF; pprot = 3'b000;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_reg15", 64'(regs_w[1][15*W +: W]), 64'd0);
    chk("midrst_d0reg2", 64'(regs_w[0][2*W +: W]), 64'd0);
    chk("midrst_pready", 64'(pready_w[1]), 64'd0);
    chk("midrst_prdata", 64'(prdata_w[1]), 64'd0);
    psel = '0; penable = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    xfer(1, 0, 32'h3C, 0, 4'h0, 3'b000, 32'h0, 0);
    xfer(1, 0, 32'h20, 0, 4'h0, 3'b000, 32'h0, 0);
    xfer(0, 0, 32'h08, 0, 4'h0, 3'b000, 32'h0, 0);
    idle();
    @(negedge clk);
    chk("midrst_no_pulse", 64'(pulse_cnt[1]), 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
